merge21_sync: RTL and testbench
===============================

// Module: merge21_sync
// PURPOSE
//  Clocked 2-to-1 packet merge for the router output port. Sits directly downstream
//  of decoder12: the Out0/Out1 streams of two neighbouring decoders converge here.
//  Round-robin arbitration at packet granularity; grant is locked until the tail flit.
//  Merged stream leaves through a 2-entry output FIFO, so out_ready never combinationally
//  reaches in*_ready.
// PARAMETERS
//  W      9   flit width incl. tail flag; bit W-1 = tail (1 = last flit of packet)
// PORTS
//  CLK        in   1   single clock, rising edge
//  _RESET     in   1   asynchronous, active-low reset
//  in0_data   in   W   flit from decoder output channel 0
//  in0_valid  in   1   in0_data valid
//  in0_ready  out  1   flit accepted on CLK edge when in0_valid & in0_ready
//  in1_data   in   W   flit from decoder output channel 1
//  in1_valid  in   1   in1_data valid
//  in1_ready  out  1   accept for in1 (same rule as in0)
//  out_data   out  W   head entry of output FIFO
//  out_valid  out  1   FIFO non-empty
//  out_ready  in   1   downstream accepts out_data when out_valid & out_ready
//  grant      out  2   one-hot owner of locked packet; 2'b00 when IDLE
// BEHAVIOUR
//  Reset (_RESET=0, async):
//   - state=IDLE, rr=0 (in0 preferred), FIFO count=0.
//   - out_valid=0, out_data=0, in0_ready=0, in1_ready=0, grant=0.
//   - Reset mid-packet drops the partial packet and flushes the FIFO.
//  Handshake:
//   - valid/ready with transfer on the CLK edge.
//   - Upstream holds data stable while valid & !ready; the block does not check this.
//  space = (count < 2), from registered count only. No push when count==2, even if a
//  pop happens the same cycle.
//  FSM states IDLE, LOCK0, LOCK1:
//   - IDLE, winner w:
//     - Only one valid: w = that input.
//     - Both valid: w = rr.
//     - Neither valid: no winner, both ready=0.
//     - in_w_ready = space; the loser's ready=0.
//     - Transfer with tail=0: go to LOCKw.
//     - Transfer with tail=1: stay IDLE, rr = ~w.
//   - LOCKx:
//     - inx_ready = space; other ready=0 regardless of its valid.
//     - Tail transfer: go to IDLE, rr = ~x.
//   - grant = 2'b01 in LOCK0, 2'b10 in LOCK1, else 0. A single-flit packet never
//     raises grant.
//  FIFO:
//   - Push on an accepted flit; pop on out_valid & out_ready.
//   - Simultaneous push/pop at count==1: count stays 1, new flit is queued behind the head.
//   - Order is preserved.
//  Latency: a flit accepted at edge N appears on out_data after edge N if the FIFO was
//  empty (1 cycle).
//  Throughput: 1 flit/cycle with out_ready held high.
//  Fairness: with both inputs saturated, packets alternate in0,in1,in0,...
//  Flits of different packets never interleave on out_data.
//  Back-pressure: out_ready=0 fills the FIFO in 2 pushes, then all in*_ready=0.
//  Lock state is held.
// TESTING
//  1. Reset: release _RESET with in0_valid=1, in0_data=9'h105 -> in0_ready=1;
//     out_valid=1, out_data=9'h105 one cycle later.
//  2. Both inputs valid with 1-flit packets (in0=9'h1A1, in1=9'h1B2 repeated),
//     out_ready=1 -> out_data alternates 1A1,1B2,1A1; grant stays 0.
//  3. in0 sends 3-flit packet 0x011,0x012,0x113 while in1 holds 9'h1FF valid
//     -> in1_ready=0 and grant=01 until 0x113 is accepted; 0x1FF follows on out_data.
//  4. out_ready=0, in0 streaming -> exactly 2 flits accepted, then in0_ready=0.
//     Raise out_ready -> data is intact and in order.
//  5. Assert _RESET mid-packet after 0x021 (tail=0) -> out_valid=0 and state IDLE at once.
//     After release, in1 wins when in0 is idle.
//  6. At count==1, push and pop in the same cycle -> count stays 1 and order is preserved.

Source files
------------

// File: rtl/merge21_sync.sv
// Clocked 2-to-1 packet merge: round-robin arbitration locked per packet,
// feeding a 2-entry output FIFO so downstream ready never reaches the inputs.
module merge21_sync #(
  parameter int W = 9
) (
  input  logic         CLK,
  input  logic         _RESET,
  input  logic [W-1:0] in0_data,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [W-1:0] in1_data,
  input  logic         in1_valid,
  output logic         in1_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   grant
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  logic [1:0]   state_q, state_d;
  logic         rr_q, rr_d;
  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;

  logic         space;
  logic         win_vld;
  logic         win_sel;
  logic         push;
  logic         pop;
  logic [W-1:0] push_data;

  // Space comes from the registered count only, so a same-cycle pop never frees a slot.
  assign space = (count_q != 2'd2);

  always_comb begin
    win_vld = 1'b0;
    win_sel = 1'b0;
    case (state_q)
      LOCK0: begin
        win_vld = 1'b1;
        win_sel = 1'b0;
      end
      LOCK1: begin
        win_vld = 1'b1;
        win_sel = 1'b1;
      end
      default: begin
        win_vld = in0_valid | in1_valid;
        win_sel = (in0_valid & in1_valid) ? rr_q : in1_valid;
      end
    endcase
  end

  // Ready is forced low while reset is held, even though the FIFO reads as empty.
  assign in0_ready = _RESET & space & win_vld & ~win_sel;
  assign in1_ready = _RESET & space & win_vld &  win_sel;

  assign push      = win_sel ? (in1_valid & in1_ready) : (in0_valid & in0_ready);
  assign push_data = win_sel ? in1_data : in0_data;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    if (push) begin
      if (push_data[W-1]) begin
        state_d = IDLE;
        rr_d    = ~win_sel;
      end else begin
        state_d = win_sel ? LOCK1 : LOCK0;
      end
    end
  end

  always_comb begin
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Storage is not reset; the empty FIFO presents zero instead.
  assign out_valid = (count_q != 2'd0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign grant     = {state_q == LOCK1, state_q == LOCK0};

endmodule

// File: tb/tb_merge21_sync.sv
// Directed bench for merge21_sync: a queue-level model checked every cycle,
// plus literal expectations on the merged output sequence of each scenario.
module tb_merge21_sync;
  localparam int W = 9;

  logic         CLK = 1'b0;
  logic         _RESET;
  logic [W-1:0] in0_data, in1_data, out_data;
  logic         in0_valid, in1_valid, in0_ready, in1_ready;
  logic         out_valid, out_ready;
  logic [1:0]   grant;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  merge21_sync #(.W(W)) dut (
    .CLK       (CLK),
    ._RESET    (_RESET),
    .in0_data  (in0_data),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in1_data  (in1_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant)
  );

  logic [W-1:0] mq[$];
  int           owner = -1;
  int           rr    = 0;
  logic [W-1:0] olog[$];
  logic [W-1:0] ex[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: queue of flits, packet owner (-1 = none) and round-robin preference.
  initial begin
    forever begin
      logic         space;
      int           w;
      logic         er0, er1, acc;
      logic [1:0]   eg;
      logic [W-1:0] d;
      @(negedge CLK);
      if (!_RESET) begin
        mq.delete();
        owner = -1;
        rr    = 0;
        chk("rst_in0_ready", in0_ready, 0);
        chk("rst_in1_ready", in1_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_grant",     grant,     0);
      end else begin
        space = (mq.size() < 2);
        w = -1;
        if (owner >= 0)                   w = owner;
        else if (in0_valid && in1_valid) w = rr;
        else if (in0_valid)              w = 0;
        else if (in1_valid)              w = 1;
        er0 = space && (w == 0);
        er1 = space && (w == 1);
        eg  = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        chk("in0_ready", in0_ready, er0);
        chk("in1_ready", in1_ready, er1);
        chk("grant",     grant,     eg);
        chk("out_valid", out_valid, mq.size() > 0);
        if (mq.size() > 0) chk("out_data", out_data, mq[0]);
        if (mq.size() > 0 && out_ready) begin
          olog.push_back(out_data);
          void'(mq.pop_front());
        end
        acc = (er0 && in0_valid) || (er1 && in1_valid);
        d   = (w == 1) ? in1_data : in0_data;
        if (acc) begin
          mq.push_back(d);
          if (d[W-1]) begin
            owner = -1;
            rr    = 1 - w;
          end else begin
            owner = w;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    _RESET    = 1'b0;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    out_ready = 1'b0;
    idle(2);
    _RESET = 1'b1;
    olog.delete();
  endtask

  // Present a flit on one input and hold it until accepted (bounded wait).
  task automatic send(input int ch, input logic [W-1:0] d);
    logic done;
    done = 1'b0;
    if (ch == 0) begin in0_valid = 1'b1; in0_data = d; end
    else         begin in1_valid = 1'b1; in1_data = d; end
    for (int i = 0; i < 20 && !done; i++) begin
      #0;
      done = (ch == 0) ? in0_ready : in1_ready;
      step();
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: ch %0d flit %0h never accepted", ch, d);
    end
  endtask

  task automatic chk_log(input string nm);
    chk({nm, "_len"}, olog.size(), ex.size());
    for (int i = 0; i < ex.size() && i < olog.size(); i++)
      chk(nm, olog[i], ex[i]);
  endtask

  initial begin
    _RESET = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    in0_data = '0; in1_data = '0;
    idle(2);

    // 1: release reset with in0 already presenting a flit
    in0_valid = 1'b1; in0_data = 9'h105; out_ready = 1'b1;
    _RESET = 1'b1;
    #1;
    chk("t1_in0_ready", in0_ready, 1);
    step();
    in0_valid = 1'b0;
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data",  out_data,  9'h105);
    idle(2);

    // 2: single-flit packets on both inputs alternate
    do_reset();
    out_ready = 1'b1;
    in0_valid = 1'b1; in0_data = 9'h1A1;
    in1_valid = 1'b1; in1_data = 9'h1B2;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t2_grant", grant, 0);
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
    idle(3);
    ex = '{9'h1A1, 9'h1B2, 9'h1A1, 9'h1B2, 9'h1A1, 9'h1B2};
    chk_log("t2_order");

    // 3: 3-flit packet from in0 locks out a waiting in1
    do_reset();
    out_ready = 1'b1;
    in1_valid = 1'b1; in1_data = 9'h1FF;
    send(0, 9'h011);
    chk("t3_grant_a", grant, 2'b01);
    chk("t3_in1_ready_a", in1_ready, 0);
    send(0, 9'h012);
    chk("t3_grant_b", grant, 2'b01);
    send(0, 9'h113);
    in0_valid = 1'b0;
    chk("t3_grant_c", grant, 0);
    idle(1);
    in1_valid = 1'b0;
    idle(3);
    ex = '{9'h011, 9'h012, 9'h113, 9'h1FF};
    chk_log("t3_order");

    // 4: back-pressure fills the FIFO in two pushes
    do_reset();
    send(0, 9'h031);
    send(0, 9'h032);
    in0_data = 9'h033;
    for (int i = 0; i < 3; i++) begin
      chk("t4_in0_blocked", in0_ready, 0);
      step();
    end
    chk("t4_grant_held", grant, 2'b01);
    out_ready = 1'b1;
    send(0, 9'h033);
    send(0, 9'h134);
    in0_valid = 1'b0;
    idle(4);
    ex = '{9'h031, 9'h032, 9'h033, 9'h134};
    chk_log("t4_order");

    // 5: reset mid-packet, then in1 wins alone
    do_reset();
    send(0, 9'h021);
    in0_valid = 1'b0;
    _RESET = 1'b0;
    #1;
    chk("t5_out_valid_now", out_valid, 0);
    chk("t5_grant_now", grant, 0);
    step();
    in1_valid = 1'b1; in1_data = 9'h1C5; out_ready = 1'b1;
    _RESET = 1'b1;
    #1;
    chk("t5_in1_ready", in1_ready, 1);
    step();
    in1_valid = 1'b0;
    chk("t5_out_data", out_data, 9'h1C5);
    idle(2);

    // 6: push and pop together at count 1
    do_reset();
    send(0, 9'h051);
    out_ready = 1'b1;
    send(0, 9'h152);
    in0_valid = 1'b0;
    chk("t6_out_valid", out_valid, 1);
    chk("t6_out_data",  out_data,  9'h152);
    step();
    chk("t6_empty", out_valid, 0);
    idle(1);
    ex = '{9'h051, 9'h152};
    chk_log("t6_order");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
    $fatal(1, "watchdog");
  end

endmodule
